// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined ripple-carry adder/subtractor.
//   OP_ADD / OP_SUB : encodings of the in_op input.
package adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/adder_chunk.sv
// Combinational C-bit ripple-carry adder chunk.
// One instance per pipeline stage.
// Ports:
//   a, b      in   C  chunk operands; b is already inverted for subtraction
//   cin       in   1  carry into bit 0 of the chunk
//   sum       out  C  chunk sum
//   cout      out  1  carry out of the chunk MSB
//   c_msb_in  out  1  carry into the chunk MSB; the top chunk uses it for signed overflow
module adder_chunk #(
    parameter int C = 2
) (
    input  logic [C-1:0] a,
    input  logic [C-1:0] b,
    input  logic         cin,
    output logic [C-1:0] sum,
    output logic         cout,
    output logic         c_msb_in
);

    always_comb begin
        logic [C:0] c;
        // NOTE: combinational blocks use blocking '=' so that each line sees
        // the value computed by the line before it, as the ripple needs.
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < C; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout     = c[C];
        c_msb_in = c[C - 1];
    end

endmodule

// File: rtl/adder_pipe_rc.sv
// Pipelined ripple-carry adder/subtractor with a valid/ready handshake.
// WIDTH-bit operands are split into STAGES chunks of C = WIDTH/STAGES bits.
// Stage k sums chunk k and registers its carry for stage k+1. The pipe holds
// up to STAGES operations and retires one per cycle while out_rdy is high.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   in_val      in   1      operand valid
//   in_rdy      out  1      operands are accepted this cycle
//   in_a, in_b  in   WIDTH  operands
//   in_cin      in   1      carry-in for ADD; ignored for SUB
//   in_op       in   1      OP_ADD / OP_SUB
//   out_val     out  1      result valid
//   out_rdy     in   1      consumer takes the result this cycle
//   out_sum     out  WIDTH  result
//   out_cout    out  1      carry out of the MSB (for SUB, 1 means no borrow)
//   out_ovf     out  1      two's-complement signed overflow
module adder_pipe_rc
    import adder_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_op,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int C = WIDTH / STAGES;

    if (STAGES < 1 || WIDTH < 2 || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("adder_pipe_rc: WIDTH must be >= 2 and a multiple of STAGES >= 1");
    end

    // Stage registers. word_r[k] holds the sum bits already produced in its
    // lower (k+1)*C bits and the untouched operand A bits above them.
    // badj_r[k] holds operand B after the ADD/SUB inversion.
    logic [STAGES-1:0] vld_r;
    logic [WIDTH-1:0]  word_r  [STAGES];
    logic [WIDTH-1:0]  badj_r  [STAGES];
    logic [STAGES-1:0] carry_r;
    logic              c_msb_r;

    // Stage inputs and chunk results.
    logic [STAGES-1:0] en;
    logic [STAGES-1:0] vin;
    logic [STAGES-1:0] cin_in;
    logic [WIDTH-1:0]  word_in [STAGES];
    logic [WIDTH-1:0]  badj_in [STAGES];
    logic [WIDTH-1:0]  word_nx [STAGES];
    logic [C-1:0]      sum_nx  [STAGES];
    logic              cout_nx [STAGES];
    logic              cmsb_nx [STAGES];

    // Ready chain, walked from the output back to the input. A stage may load
    // when it is empty or when its own content moves on this cycle.
    always_comb begin
        logic go;
        go = out_rdy;
        en = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            en[k] = !vld_r[k] || go;
            go    = en[k];
        end
    end

    assign in_rdy = en[0];

    // Stage 0 is fed from the ports; every later stage is fed from the
    // registers of the stage before it.
    always_comb begin
        vin[0]     = in_val;
        word_in[0] = in_a;
        badj_in[0] = (in_op == OP_SUB) ? ~in_b : in_b;
        cin_in[0]  = (in_op == OP_SUB) ? 1'b1 : in_cin;
        for (int k = 1; k < STAGES; k++) begin
            vin[k]     = vld_r[k - 1];
            word_in[k] = word_r[k - 1];
            badj_in[k] = badj_r[k - 1];
            cin_in[k]  = carry_r[k - 1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_chunk #(
            .C (C)
        ) u_chunk (
            .a        (word_in[k][k*C +: C]),
            .b        (badj_in[k][k*C +: C]),
            .cin      (cin_in[k]),
            .sum      (sum_nx[k]),
            .cout     (cout_nx[k]),
            .c_msb_in (cmsb_nx[k])
        );
    end

    // Replace chunk k of the running word with the freshly computed sum bits.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            word_nx[k]             = word_in[k];
            word_nx[k][k*C +: C]   = sum_nx[k];
        end
    end

    // Data registers load only when a valid operation enters the stage, so
    // a stalled output stage and bubbles leave the held result untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data registers are reset as well as the valid bits,
            // because the output stage drives out_sum/out_cout/out_ovf
            // directly and those must read zero after reset.
            vld_r   <= '0;
            carry_r <= '0;
            c_msb_r <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                word_r[k] <= '0;
                badj_r[k] <= '0;
            end
        end else begin
            // NOTE: state updates use non-blocking '<=' so every stage samples
            // its predecessor's pre-edge value and the pipe shifts by one.
            for (int k = 0; k < STAGES; k++) begin
                if (en[k]) begin
                    vld_r[k] <= vin[k];
                end
                if (en[k] && vin[k]) begin
                    word_r[k]  <= word_nx[k];
                    badj_r[k]  <= badj_in[k];
                    carry_r[k] <= cout_nx[k];
                end
            end
            if (en[STAGES-1] && vin[STAGES-1]) begin
                c_msb_r <= cmsb_nx[STAGES-1];
            end
        end
    end

    assign out_val  = vld_r[STAGES-1];
    assign out_sum  = word_r[STAGES-1];
    assign out_cout = carry_r[STAGES-1];
    // Signed overflow: carry into the MSB differs from carry out of it.
    assign out_ovf  = c_msb_r ^ carry_r[STAGES-1];

endmodule

// File: tb/tb_adder_pipe_rc.sv
// Self-checking bench for adder_pipe_rc at WIDTH=8, STAGES=4.
module tb_adder_pipe_rc;
    import adder_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       in_val;
    logic       in_rdy;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_cin;
    logic       in_op;
    logic       out_val;
    logic       out_rdy;
    logic [7:0] out_sum;
    logic       out_cout;
    logic       out_ovf;

    adder_pipe_rc #(
        .WIDTH  (8),
        .STAGES (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_cin   (in_cin),
        .in_op    (in_op),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_sum  (out_sum),
        .out_cout (out_cout),
        .out_ovf  (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Results are packed as {cout, ovf, sum}.
    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];
    int         got_t[$];

    logic       s_in_rdy;
    logic       s_acc;
    logic       s_out_val;
    logic [9:0] s_out;

    // Independent reference: integer add, overflow from operand/result signs.
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic cin, input logic op);
        logic [7:0] bb;
        logic       c0;
        logic [8:0] full;
        logic       ovf;
        bb   = op ? ~b : b;
        c0   = op ? 1'b1 : cin;
        full = {1'b0, a} + {1'b0, bb} + {8'd0, c0};
        ovf  = (a[7] == bb[7]) && (full[7] != a[7]);
        return {full[8], ovf, full[7:0]};
    endfunction

    // Called at a negedge with inputs already driven: samples the cycle's
    // handshakes 1 time unit later and returns at the next negedge.
    task automatic tick();
        #1;
        s_in_rdy  = in_rdy;
        s_acc     = in_val && in_rdy && rst_n;
        s_out_val = out_val;
        s_out     = {out_cout, out_ovf, out_sum};
        if (s_acc) exp_q.push_back(model(in_a, in_b, in_cin, in_op));
        if (out_val && out_rdy && rst_n) begin
            got_q.push_back(s_out);
            got_t.push_back(cyc);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic clear_q();
        exp_q.delete();
        got_q.delete();
        got_t.delete();
    endtask

    task automatic drain(input int n_want);
        int budget;
        budget = 0;
        in_val = 1'b0;
        out_rdy = 1'b1;
        while (got_q.size() < n_want && budget < 40) begin
            tick();
            budget++;
        end
    endtask

    task automatic test_reset();
        #1;
        n_vec++;
        if (out_val !== 1'b0) begin n_bad++; $display("FAIL reset_out_val: got %b want 0", out_val); end
        n_vec++;
        if (out_sum !== 8'h00) begin n_bad++; $display("FAIL reset_out_sum: got %h want 00", out_sum); end
        n_vec++;
        if (out_cout !== 1'b0) begin n_bad++; $display("FAIL reset_out_cout: got %b want 0", out_cout); end
        n_vec++;
        if (out_ovf !== 1'b0) begin n_bad++; $display("FAIL reset_out_ovf: got %b want 0", out_ovf); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (in_rdy !== 1'b1) begin n_bad++; $display("FAIL reset_in_rdy: got %b want 1", in_rdy); end
        @(negedge clk);
    endtask

    // One operation through an idle pipe; hand-computed result and latency.
    task automatic test_single(input string name, input logic [7:0] a, input logic [7:0] b,
                               input logic cin, input logic op, input logic [7:0] e_sum,
                               input logic e_cout, input logic e_ovf);
        int lat;
        clear_q();
        out_rdy = 1'b1;
        in_val = 1'b1; in_a = a; in_b = b; in_cin = cin; in_op = op;
        tick();
        n_vec++;
        if (s_acc !== 1'b1) begin n_bad++; $display("FAIL %s_accept: got %b want 1", name, s_acc); end
        in_val = 1'b0;
        lat = 0;
        while (got_q.size() == 0 && lat < 12) begin
            tick();
            lat++;
        end
        n_vec++;
        if (lat != 4 || got_q.size() != 1) begin
            n_bad++;
            $display("FAIL %s_latency: got %0d cycles (%0d results) want 4 cycles", name, lat, got_q.size());
        end
        if (got_q.size() > 0) begin
            n_vec++;
            if (got_q[0] !== {e_cout, e_ovf, e_sum}) begin
                n_bad++;
                $display("FAIL %s_result: got cout=%b ovf=%b sum=%h want cout=%b ovf=%b sum=%h",
                         name, got_q[0][9], got_q[0][8], got_q[0][7:0], e_cout, e_ovf, e_sum);
            end
        end
        clear_q();
    endtask

    task automatic test_back_to_back();
        int t0;
        clear_q();
        out_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_val = 1'b1;
            in_a   = 8'(i * 37 + 3);
            in_b   = 8'(i * 91 + 200);
            in_cin = i[0];
            in_op  = i[1];
            tick();
            n_vec++;
            if (s_in_rdy !== 1'b1) begin n_bad++; $display("FAIL b2b_in_rdy[%0d]: got %b want 1", i, s_in_rdy); end
        end
        drain(8);
        n_vec++;
        if (got_q.size() != 8) begin n_bad++; $display("FAIL b2b_count: got %0d want 8", got_q.size()); end
        t0 = (got_t.size() > 0) ? got_t[0] : 0;
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i] || got_t[i] != t0 + i) begin
                n_bad++;
                $display("FAIL b2b_result[%0d]: got %h at +%0d want %h at +%0d", i, got_q[i], got_t[i] - t0, exp_q[i], i);
            end
        end
        clear_q();
    endtask

    task automatic test_backpressure();
        int         acc;
        logic [9:0] held;
        int         n_exp;
        clear_q();
        acc = 0;
        held = '0;
        out_rdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_val = 1'b1;
            in_a   = 8'(8'h10 + i * 17);
            in_b   = 8'(8'h33 + i * 29);
            in_cin = 1'b1;
            in_op  = i[0];
            tick();
            if (s_acc) acc++;
            if (i == 4) held = s_out;
            if (i == 5) begin
                n_vec++;
                if (s_in_rdy !== 1'b0) begin n_bad++; $display("FAIL bp_full_in_rdy: got %b want 0", s_in_rdy); end
                n_vec++;
                if (s_out_val !== 1'b1 || s_out !== held) begin
                    n_bad++;
                    $display("FAIL bp_hold: got val=%b out=%h want val=1 out=%h", s_out_val, s_out, held);
                end
            end
        end
        n_vec++;
        if (acc != 4) begin n_bad++; $display("FAIL bp_accepted: got %0d want 4", acc); end
        out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_val = 1'b1;
            in_a   = 8'(8'hC0 + i);
            in_b   = 8'(8'h41 * (i + 1));
            in_cin = 1'b0;
            in_op  = OP_ADD;
            tick();
            n_vec++;
            if (s_in_rdy !== 1'b1 || s_out_val !== 1'b1) begin
                n_bad++;
                $display("FAIL bp_flow[%0d]: got in_rdy=%b out_val=%b want 1 1", i, s_in_rdy, s_out_val);
            end
        end
        n_exp = exp_q.size();
        drain(n_exp);
        n_vec++;
        if (got_q.size() != 8 || n_exp != 8) begin
            n_bad++;
            $display("FAIL bp_count: got %0d results for %0d accepted want 8", got_q.size(), n_exp);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL bp_result[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        clear_q();
    endtask

    task automatic test_mid_reset();
        clear_q();
        out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_val = 1'b1; in_a = 8'(i + 1); in_b = 8'h20; in_cin = 1'b0; in_op = OP_ADD;
            tick();
        end
        in_val = 1'b0;
        rst_n  = 1'b0;
        #1;
        n_vec++;
        if (out_val !== 1'b0) begin n_bad++; $display("FAIL mrst_out_val: got %b want 0", out_val); end
        @(negedge clk);
        rst_n = 1'b1;
        clear_q();
        out_rdy = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        n_vec++;
        if (got_q.size() != 0) begin n_bad++; $display("FAIL mrst_stale: got %0d results want 0", got_q.size()); end
        n_vec++;
        if (s_in_rdy !== 1'b1) begin n_bad++; $display("FAIL mrst_in_rdy: got %b want 1", s_in_rdy); end
        clear_q();
    endtask

    task automatic test_random();
        int sent;
        int budget;
        int n_exp;
        clear_q();
        sent = 0;
        budget = 0;
        while (sent < 300 && budget < 5000) begin
            in_val  = ($urandom_range(0, 3) != 0);
            in_a    = 8'($urandom_range(0, 255));
            in_b    = 8'($urandom_range(0, 255));
            in_cin  = 1'($urandom_range(0, 1));
            in_op   = 1'($urandom_range(0, 1));
            out_rdy = ($urandom_range(0, 3) != 0);
            tick();
            if (s_acc) sent++;
            budget++;
        end
        n_exp = exp_q.size();
        drain(n_exp);
        n_vec++;
        if (got_q.size() != n_exp || n_exp != 300) begin
            n_bad++;
            $display("FAIL rnd_count: got %0d results for %0d accepted want 300", got_q.size(), n_exp);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rnd_result[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        clear_q();
    endtask

    initial begin
        rst_n = 1'b0; in_val = 1'b0; in_a = '0; in_b = '0;
        in_cin = 1'b0; in_op = OP_ADD; out_rdy = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_single("add_ovf",   8'h7F, 8'h01, 1'b0, OP_ADD, 8'h80, 1'b0, 1'b1);
        test_single("add_ripple",8'hFF, 8'h01, 1'b0, OP_ADD, 8'h00, 1'b1, 1'b0);
        test_single("add_cin",   8'h0F, 8'h00, 1'b1, OP_ADD, 8'h10, 1'b0, 1'b0);
        test_single("sub_borrow",8'h05, 8'h07, 1'b1, OP_SUB, 8'hFE, 1'b0, 1'b0);
        test_single("sub_ovf",   8'h80, 8'h01, 1'b0, OP_SUB, 8'h7F, 1'b1, 1'b1);
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
